// File: rtl/wb_stage_param_if.sv
// MEM->WB handshake bundle: mem_over/wb_allow_in plus the instruction payload MEM hands to writeback.
interface wb_stage_param_if #(
  parameter int DATA_W = 32,
  parameter int RF_AW  = 5
);
  logic              mem_over;
  logic              wb_allow_in;
  logic [DATA_W-1:0] mem_alu_res;
  logic [DATA_W-1:0] mem_load_data;
  logic [DATA_W-1:0] mem_pc8;
  logic [RF_AW-1:0]  mem_waddr;
  logic [2:0]        mem_rfwd_sel;
  logic [2:0]        mem_ext_func;
  logic              mem_rf_wen;
  logic              mem_hi_wen;
  logic              mem_lo_wen;
  logic              mem_lo_sel;
  logic              mem_pcw_sel;

  modport master (
    output mem_over, mem_alu_res, mem_load_data, mem_pc8, mem_waddr,
           mem_rfwd_sel, mem_ext_func, mem_rf_wen, mem_hi_wen, mem_lo_wen,
           mem_lo_sel, mem_pcw_sel,
    input  wb_allow_in
  );

  modport slave (
    input  mem_over, mem_alu_res, mem_load_data, mem_pc8, mem_waddr,
           mem_rfwd_sel, mem_ext_func, mem_rf_wen, mem_hi_wen, mem_lo_wen,
           mem_lo_sel, mem_pcw_sel,
    output wb_allow_in
  );
endinterface

// File: rtl/wb_stage_param.sv
// Writeback stage: registered payload, HI/LO, load extension, RF write select; WB_COMMIT_TRACE_EN adds retire trace.
// Commits 1 cycle after accept; a busy RF port (rf_ready=0) holds the instruction and drops wb_allow_in.
module wb_stage_param #(
  parameter int              DATA_W     = 32,
  parameter int              RF_AW      = 5,
  parameter logic [DATA_W-1:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cancel,
  wb_stage_param_if.slave   mif,
  input  logic [DATA_W-1:0] cp0_rdata,
  input  logic              rf_ready,
  output logic              wb_valid,
  output logic              rf_wen,
  output logic [RF_AW-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] wb_pcw,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
`ifdef WB_COMMIT_TRACE_EN
  ,
  output logic              trace_valid,
  output logic [DATA_W-1:0] trace_pc,
  output logic [31:0]       retire_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] pc8;
    logic [RF_AW-1:0]  waddr;
    logic [2:0]        rfwd_sel;
    logic [2:0]        ext_func;
    logic              rf_wen;
    logic              hi_wen;
    logic              lo_wen;
    logic              lo_sel;
    logic              pcw_sel;
  } wb_pay_t;

  wb_pay_t           pay_q;
  wb_pay_t           pay_d;
  logic              wb_over;
  logic              accept;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] load_ext;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign wb_over         = wb_valid & rf_ready & ~cancel;
  assign mif.wb_allow_in = ~wb_valid | wb_over;
  assign accept          = mif.mem_over & mif.wb_allow_in & ~cancel;

  always_comb begin
    pay_d           = pay_q;
    pay_d.alu_res   = mif.mem_alu_res;
    pay_d.load_data = mif.mem_load_data;
    pay_d.pc8       = mif.mem_pc8;
    pay_d.waddr     = mif.mem_waddr;
    pay_d.rfwd_sel  = mif.mem_rfwd_sel;
    pay_d.ext_func  = mif.mem_ext_func;
    pay_d.rf_wen    = mif.mem_rf_wen;
    pay_d.hi_wen    = mif.mem_hi_wen;
    pay_d.lo_wen    = mif.mem_lo_wen;
    pay_d.lo_sel    = mif.mem_lo_sel;
    pay_d.pcw_sel   = mif.mem_pcw_sel;
  end

  // Cancel outranks accept: a flushed edge neither captures nor keeps anything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      pay_q    <= '0;
    end else if (cancel) begin
      wb_valid <= 1'b0;
    end else if (mif.wb_allow_in) begin
      wb_valid <= mif.mem_over;
      if (accept) begin
        pay_q <= pay_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb_over) begin
      if (pay_q.hi_wen) begin
        hi_q <= pay_q.alu_res;
      end
      if (pay_q.lo_wen) begin
        lo_q <= pay_q.lo_sel ? pay_q.load_data : pay_q.alu_res;
      end
    end
  end

  always_comb begin
    ld_byte = pay_q.load_data[7:0];
    case (pay_q.alu_res[1:0])
      2'd0:    ld_byte = pay_q.load_data[7:0];
      2'd1:    ld_byte = pay_q.load_data[15:8];
      2'd2:    ld_byte = pay_q.load_data[23:16];
      default: ld_byte = pay_q.load_data[31:24];
    endcase
    ld_half = pay_q.alu_res[1] ? pay_q.load_data[31:16] : pay_q.load_data[15:0];
  end

  always_comb begin
    load_ext = pay_q.load_data;
    case (pay_q.ext_func)
      3'd1:    load_ext = {{(DATA_W-8){1'b0}}, ld_byte};
      3'd2:    load_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'd3:    load_ext = {{(DATA_W-16){1'b0}}, ld_half};
      3'd4:    load_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
      default: load_ext = pay_q.load_data;
    endcase
  end

  always_comb begin
    rf_wdata = pay_q.alu_res;
    case (pay_q.rfwd_sel)
      3'd1:    rf_wdata = pay_q.pc8;
      3'd2:    rf_wdata = hi_q;
      3'd3:    rf_wdata = lo_q;
      3'd4:    rf_wdata = load_ext;
      3'd5:    rf_wdata = cp0_rdata;
      default: rf_wdata = pay_q.alu_res;
    endcase
  end

  assign rf_wen   = wb_over & pay_q.rf_wen & (pay_q.waddr != '0);
  assign rf_waddr = rf_wen ? pay_q.waddr : '0;
  assign wb_pcw   = pay_q.pcw_sel ? cp0_rdata : EXC_VECTOR;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

`ifdef WB_COMMIT_TRACE_EN
  assign trace_valid = wb_over;
  assign trace_pc    = pay_q.pc8 - DATA_W'(8);

  always_ff @(posedge clk) begin
    if (!reset) begin
      retire_cnt <= '0;
    end else if (wb_over) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_param.sv
// Directed bench for wb_stage_param: RF commits are checked against a queue filled as instructions are issued.
module tb_wb_stage_param;
  logic        clk = 1'b0;
  logic        reset;
  logic        cancel;
  logic [31:0] cp0_rdata;
  logic        rf_ready;
  logic        wb_valid;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] wb_pcw;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
`ifdef WB_COMMIT_TRACE_EN
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] retire_cnt;
`endif

  wb_stage_param_if #(.DATA_W(32), .RF_AW(5)) mif ();

  wb_stage_param #(.DATA_W(32), .RF_AW(5), .EXC_VECTOR(32'hBFC00380)) dut (
    .clk(clk), .reset(reset), .cancel(cancel), .mif(mif),
    .cp0_rdata(cp0_rdata), .rf_ready(rf_ready), .wb_valid(wb_valid),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_pcw(wb_pcw), .hi_out(hi_out), .lo_out(lo_out)
`ifdef WB_COMMIT_TRACE_EN
    , .trace_valid(trace_valid), .trace_pc(trace_pc), .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   ncommit = 0;
  int   c0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every RF strobe must match the oldest outstanding expectation.
  task automatic monitor();
    exp_t e;
    if (rf_wen === 1'b1) begin
      ncommit++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_wen observed addr=%h data=%h expected no write", rf_waddr, rf_wdata);
      end else begin
        e = q.pop_front();
        chk("commit_addr", 64'(rf_waddr), 64'(e.addr));
        chk("commit_data", 64'(rf_wdata), 64'(e.data));
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    monitor();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    at_neg();
    to_pos();
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [2:0] sel, input logic [2:0] ext,
                        input logic rfw, input logic hiw, input logic low, input logic losel,
                        input logic pcws);
    mif.mem_alu_res  = alu;
    mif.mem_rfwd_sel = sel;
    mif.mem_ext_func = ext;
    mif.mem_rf_wen   = rfw;
    mif.mem_hi_wen   = hiw;
    mif.mem_lo_wen   = low;
    mif.mem_lo_sel   = losel;
    mif.mem_pcw_sel  = pcws;
  endtask

  task automatic issue(input logic [4:0] a, input logic [31:0] exp, input bit push);
    exp_t e;
    mif.mem_waddr = a;
    mif.mem_over  = 1'b1;
    if (push && mif.mem_rf_wen && a != 5'd0) begin
      e.addr = a;
      e.data = exp;
      q.push_back(e);
    end
  endtask

  task automatic go(input logic [4:0] a, input logic [31:0] exp);
    issue(a, exp, 1'b1);
    step();
  endtask

  task automatic idle();
    mif.mem_over = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b0; cancel = 1'b0; rf_ready = 1'b1; cp0_rdata = 32'h0;
    mif.mem_over = 1'b0; mif.mem_load_data = 32'h0; mif.mem_pc8 = 32'h0; mif.mem_waddr = 5'd0;
    set_op(32'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    at_neg();
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_allow_in", 64'(mif.wb_allow_in), 64'd1);
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_pcw", 64'(wb_pcw), 64'hBFC00380);
`ifdef WB_COMMIT_TRACE_EN
    chk("rst_retire_cnt", 64'(retire_cnt), 64'd0);
`endif
    to_pos();
    reset = 1'b1;

    // Back-to-back: three commits on consecutive cycles.
    set_op(32'h11, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    go(5'd1, 32'h11);
    c0 = ncommit;
    mif.mem_alu_res = 32'h22; go(5'd2, 32'h22);
    mif.mem_alu_res = 32'h33; go(5'd3, 32'h33);
    idle();
    chk("b2b_count", 64'(ncommit - c0), 64'd3);
    idle();

    // Load extension on 32'h8899AABB.
    mif.mem_load_data = 32'h8899AABB;
    set_op(32'h1, 3'd4, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); go(5'd4, 32'hFFFFFFAA);
    set_op(32'h0, 3'd4, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); go(5'd5, 32'h000000BB);
    set_op(32'h2, 3'd4, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); go(5'd6, 32'hFFFF8899);
    set_op(32'h2, 3'd4, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); go(5'd7, 32'h00008899);
    set_op(32'h3, 3'd4, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); go(5'd19, 32'hFFFFFF88);
    set_op(32'h1, 3'd4, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); go(5'd20, 32'h8899AABB);
    idle();

    // Stall: RF busy for two cycles with the next instruction waiting.
    set_op(32'h88, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); go(5'd8, 32'h88);
    rf_ready = 1'b0;
    set_op(32'h99, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); issue(5'd9, 32'h99, 1'b1);
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("stall_valid", 64'(wb_valid), 64'd1);
      chk("stall_allow_in", 64'(mif.wb_allow_in), 64'd0);
      chk("stall_rf_wen", 64'(rf_wen), 64'd0);
      chk("stall_held", 64'(rf_wdata), 64'h88);
      to_pos();
    end
    rf_ready = 1'b1;
    at_neg();
    chk("stall_release_allow", 64'(mif.wb_allow_in), 64'd1);
    to_pos();
    idle();
    idle();

    // mthi then mfhi back-to-back; mtlo from load data then mflo.
    set_op(32'h5, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); go(5'd0, 32'h0);
    set_op(32'h0, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); go(5'd10, 32'h5);
    mif.mem_load_data = 32'h1234;
    set_op(32'h3, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); go(5'd0, 32'h0);
    set_op(32'h0, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); go(5'd11, 32'h1234);
    idle();
    chk("hi_after_mthi", 64'(hi_out), 64'h5);
    chk("lo_after_mtlo", 64'(lo_out), 64'h1234);

    // mthi killed by cancel leaves HI alone.
    set_op(32'h77, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); go(5'd0, 32'h0);
    mif.mem_over = 1'b0;
    cancel = 1'b1;
    at_neg();
    chk("cancel_hold_valid", 64'(wb_valid), 64'd1);
    to_pos();
    cancel = 1'b0;
    at_neg();
    chk("cancel_hi", 64'(hi_out), 64'h5);
    chk("cancel_hi_valid", 64'(wb_valid), 64'd0);
    to_pos();

    // CP0 read data into RF and onto the redirect PC.
    cp0_rdata = 32'hCAFE0004;
    set_op(32'h0, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); go(5'd14, 32'hCAFE0004);
    mif.mem_over = 1'b0;
    at_neg();
    chk("pcw_cp0", 64'(wb_pcw), 64'hCAFE0004);
    to_pos();

    // Cancel while MEM offers an instruction: nothing captured.
    set_op(32'hC, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); issue(5'd12, 32'hC, 1'b0);
    cancel = 1'b1;
    step();
    cancel = 1'b0; mif.mem_over = 1'b0;
    at_neg();
    chk("cancel_in_valid", 64'(wb_valid), 64'd0);
    chk("cancel_in_wen", 64'(rf_wen), 64'd0);
    to_pos();

    // Cancel an instruction already held in WB.
    issue(5'd13, 32'hC, 1'b0);
    step();
    mif.mem_over = 1'b0; cancel = 1'b1;
    at_neg();
    chk("cancel_held_wen", 64'(rf_wen), 64'd0);
    to_pos();
    cancel = 1'b0;
    at_neg();
    chk("cancel_held_valid", 64'(wb_valid), 64'd0);
    to_pos();

    // Reset during a stall discards the instruction.
    set_op(32'hD, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); issue(5'd15, 32'hD, 1'b0);
    step();
    mif.mem_over = 1'b0; rf_ready = 1'b0;
    at_neg();
    chk("rst_stall_allow", 64'(mif.wb_allow_in), 64'd0);
    to_pos();
    reset = 1'b0;
    at_neg();
    chk("rst_edge_wen", 64'(rf_wen), 64'd0);
    to_pos();
    reset = 1'b1;
    at_neg();
    chk("rst2_valid", 64'(wb_valid), 64'd0);
    chk("rst2_allow_in", 64'(mif.wb_allow_in), 64'd1);
    chk("rst2_rf_waddr", 64'(rf_waddr), 64'd0);
    chk("rst2_hi", 64'(hi_out), 64'd0);
    chk("rst2_lo", 64'(lo_out), 64'd0);
`ifdef WB_COMMIT_TRACE_EN
    chk("rst2_retire_cnt", 64'(retire_cnt), 64'd0);
`endif
    to_pos();
    rf_ready = 1'b1;

    // Write to r0 never strobes the RF; then three more retirements.
    mif.mem_pc8 = 32'h108;
    set_op(32'h1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); go(5'd0, 32'h0);
    mif.mem_over = 1'b0;
    at_neg();
    chk("r0_valid", 64'(wb_valid), 64'd1);
    chk("r0_wen", 64'(rf_wen), 64'd0);
    chk("r0_waddr", 64'(rf_waddr), 64'd0);
`ifdef WB_COMMIT_TRACE_EN
    chk("trace_valid", 64'(trace_valid), 64'd1);
    chk("trace_pc", 64'(trace_pc), 64'h100);
`endif
    to_pos();
    mif.mem_pc8 = 32'h20C; go(5'd16, 32'h1);
    mif.mem_pc8 = 32'h310;
    set_op(32'h2, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); go(5'd17, 32'h310);
    mif.mem_pc8 = 32'h414;
    set_op(32'h3, 3'd7, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); go(5'd18, 32'h3);
    idle();
    idle();
`ifdef WB_COMMIT_TRACE_EN
    chk("retire_cnt", 64'(retire_cnt), 64'd4);
`endif
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
